// File: rtl/nested_loop_ctrl_pkg.sv
// nested_loop_ctrl_pkg: shared state encoding and default widths for the nested-loop sequencer
package nested_loop_ctrl_pkg;
  localparam int MAX_LOOPS_DEF = 8;
  localparam int LOOP_ID_W_DEF = 3;
  localparam int LOOP_ITER_W_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/loop_counter_stage.sv
// loop_counter_stage: one loop level (trip register + counter); clear/inc/wrap/active in, at_max/count out
module loop_counter_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_v,
  input  logic [W-1:0] cfg_iter,
  input  logic         clear,
  input  logic         inc,
  input  logic         wrap,
  input  logic         active,
  output logic         at_max,
  output logic [W-1:0] count
);
  logic [W-1:0] trip;
  always_ff @(posedge clk)
    if (rst) begin
      trip <= '0;
      count <= '0;
    end else begin
      if (cfg_v) trip <= cfg_iter;
      count <= (clear || wrap || !active) ? '0 : inc ? count + 1'b1 : count;
    end
  assign at_max = !active || count == trip;
endmodule

// File: rtl/nested_loop_ctrl.sv
// nested_loop_ctrl: nested-loop step sequencer; cfg_* program trips/loops, start/stop/stall control, registered step strobes, status and packed counters out
module nested_loop_ctrl
  import nested_loop_ctrl_pkg::*;
#(
  parameter int MAX_LOOPS = MAX_LOOPS_DEF,
  parameter int LOOP_ID_W = LOOP_ID_W_DEF,
  parameter int LOOP_ITER_W = LOOP_ITER_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0]           cfg_loop_iter,
  input  logic [LOOP_ID_W-1:0]             cfg_loop_iter_loop_id,
  input  logic [LOOP_ID_W:0]               cfg_num_loops,
  input  logic                             cfg_repeat,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             stall,
  output logic                             busy,
  output logic                             done,
  output logic [LOOP_ID_W-1:0]             loop_index,
  output logic                             loop_index_valid,
  output logic                             loop_last_iter,
  output logic                             loop_init,
  output logic                             loop_enter,
  output logic                             loop_exit,
  output logic [MAX_LOOPS*LOOP_ITER_W-1:0] loop_counters
);
  state_t state, state_d;
  logic [LOOP_ID_W:0] nl_q, nl_d;
  logic [MAX_LOOPS-1:0] at_max;
  logic [LOOP_ID_W-1:0] k;
  logic rep_q, stop_q, fresh, step, fin, clear, busy_d, init_d, done_d;
  assign nl_d = cfg_num_loops == '0 ? (LOOP_ID_W+1)'(1)
              : cfg_num_loops > (LOOP_ID_W+1)'(MAX_LOOPS) ? (LOOP_ID_W+1)'(MAX_LOOPS) : cfg_num_loops;
  assign fin = &at_max;
  assign clear = state_d == S_INIT;
  always_comb begin
    k = '0;
    for (int i = MAX_LOOPS - 1; i >= 0; i--) if (!at_max[i]) k = LOOP_ID_W'(i);
  end
  always_comb begin
    state_d = state;
    step = 1'b0;
    busy_d = busy;
    init_d = 1'b0;
    done_d = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_d = S_INIT;
        init_d = 1'b1;
        busy_d = 1'b1;
      end
      S_INIT: begin
        state_d = S_RUN;
        step = !stall;
      end
      S_RUN: if (loop_last_iter) begin
        init_d = rep_q && !stop_q && !stop;
        done_d = !init_d;
        busy_d = init_d;
        state_d = init_d ? S_INIT : S_DONE;
      end else step = !stall;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      nl_q <= '0;
      rep_q <= 1'b0;
      stop_q <= 1'b0;
      fresh <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      loop_init <= 1'b0;
      loop_index_valid <= 1'b0;
      loop_last_iter <= 1'b0;
      loop_exit <= 1'b0;
      loop_enter <= 1'b0;
      loop_index <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && start) begin
        nl_q <= nl_d;
        rep_q <= cfg_repeat;
      end
      stop_q <= state != S_IDLE && (stop_q || (stop && state != S_DONE));
      fresh <= clear || (fresh && !step);
      busy <= busy_d;
      done <= done_d;
      loop_init <= init_d;
      loop_index_valid <= step;
      loop_last_iter <= step && fin;
      loop_exit <= step && fin;
      loop_enter <= step && fresh;
      loop_index <= !step ? '0 : fin ? LOOP_ID_W'(nl_q - 1'b1) : k;
    end
  for (genvar g = 0; g < MAX_LOOPS; g++) begin : g_stage
    loop_counter_stage #(.W(LOOP_ITER_W)) u_stage (
      .clk(clk),
      .rst(reset),
      .cfg_v(cfg_loop_iter_v && state == S_IDLE && cfg_loop_iter_loop_id == LOOP_ID_W'(g)),
      .cfg_iter(cfg_loop_iter),
      .clear(clear),
      .inc(step && !fin && k == LOOP_ID_W'(g)),
      .wrap(step && !fin && LOOP_ID_W'(g) < k),
      .active((LOOP_ID_W+1)'(g) < nl_q),
      .at_max(at_max[g]),
      .count(loop_counters[g*LOOP_ITER_W +: LOOP_ITER_W])
    );
  end
endmodule

// File: tb/tb_nested_loop_ctrl.sv
// tb_nested_loop_ctrl: randomized run-level check of nested_loop_ctrl against a mixed-radix step model
module tb_nested_loop_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_loop_iter_v = 1'b0;
  logic [15:0] cfg_loop_iter = '0;
  logic [2:0] cfg_loop_iter_loop_id = '0;
  logic [3:0] cfg_num_loops = '0;
  logic cfg_repeat = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic stall = 1'b0;
  logic busy, done, loop_index_valid, loop_last_iter, loop_init, loop_enter, loop_exit;
  logic [2:0] loop_index;
  logic [127:0] loop_counters;
  int n_chk = 0;
  int n_bad = 0;
  int trips[8] = '{default: 0};

  always #5 clk = ~clk;

  nested_loop_ctrl dut (
    .clk(clk), .reset(reset),
    .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
    .cfg_loop_iter_loop_id(cfg_loop_iter_loop_id), .cfg_num_loops(cfg_num_loops),
    .cfg_repeat(cfg_repeat), .start(start), .stop(stop), .stall(stall),
    .busy(busy), .done(done), .loop_index(loop_index), .loop_index_valid(loop_index_valid),
    .loop_last_iter(loop_last_iter), .loop_init(loop_init), .loop_enter(loop_enter),
    .loop_exit(loop_exit), .loop_counters(loop_counters)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_index"}, loop_index, 0);
    chk({tag, "_valid"}, loop_index_valid, 0);
    chk({tag, "_last"}, loop_last_iter, 0);
    chk({tag, "_init"}, loop_init, 0);
    chk({tag, "_enter"}, loop_enter, 0);
    chk({tag, "_exit"}, loop_exit, 0);
    chk({tag, "_counters"}, loop_counters, 0);
  endtask

  // counter vector for position v in the mixed-radix space of the active loops
  function automatic logic [127:0] ctr_of(input int v, input int n);
    logic [127:0] r = '0;
    int x = v;
    for (int i = 0; i < n; i++) begin
      r[i*16 +: 16] = 16'(x % (trips[i] + 1));
      x = x / (trips[i] + 1);
    end
    return r;
  endfunction

  // loop that moves when going from position s-1 to s: the lowest non-zero digit of s
  function automatic int idx_of(input int s, input int n, input int total);
    int x = s;
    if (s == total) return n - 1;
    for (int i = 0; i < n; i++) begin
      if (x % (trips[i] + 1) != 0) return i;
      x = x / (trips[i] + 1);
    end
    return 0;
  endfunction

  task automatic wr(input int id, input int v);
    cfg_loop_iter_v = 1'b1;
    cfg_loop_iter_loop_id = 3'(id);
    cfg_loop_iter = 16'(v);
    @(negedge clk);
    cfg_loop_iter_v = 1'b0;
    trips[id] = v;
  endtask

  task automatic do_run(input int ncfg, input bit rep, input int stop_pass, input int stall_pct,
                        input bit poke, input int rst_step);
    int n, total, s, pass;
    bit stl, stopped, want_init, want_done, fin, stepped;
    n = ncfg == 0 ? 1 : (ncfg > 8 ? 8 : ncfg);
    total = 1;
    for (int i = 0; i < n; i++) total *= trips[i] + 1;
    cfg_num_loops = 4'(ncfg);
    cfg_repeat = rep;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_num_loops = 4'($urandom_range(0, 15));
    cfg_repeat = 1'($urandom_range(0, 1));
    stl = 0; stopped = 0; want_init = 1; want_done = 0; fin = 0; s = 0; pass = 0;
    for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
      stepped = 0;
      cfg_loop_iter_v = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      if (want_done) begin
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", loop_index_valid, 0);
        chk("init_at_done", loop_init, 0);
        chk("counters_at_done", loop_counters, ctr_of(total - 1, n));
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        fin = 1;
      end else if (want_init) begin
        chk("init", loop_init, 1);
        chk("busy_at_init", busy, 1);
        chk("valid_at_init", loop_index_valid, 0);
        chk("counters_at_init", loop_counters, 0);
        want_init = 0;
        s = 0;
      end else begin
        chk("init_off", loop_init, 0);
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        if (!stl) begin
          s++;
          stepped = 1;
        end
        chk("valid", loop_index_valid, stepped);
        chk("index", loop_index, stepped ? idx_of(s, n, total) : 0);
        chk("last", loop_last_iter, stepped && s == total);
        chk("exit", loop_exit, stepped && s == total);
        chk("enter", loop_enter, stepped && s == 1);
        chk("counters", loop_counters, ctr_of(s == total ? total - 1 : s, n));
      end
      if (!fin) begin
        if (stepped && rst_step == s && s < total) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk_zero("after_reset");
          for (int i = 0; i < 8; i++) trips[i] = 0;
          repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
            chk("no_busy_after_reset", busy, 0);
          end
          fin = 1;
        end else begin
          stall = ($urandom_range(0, 99) < stall_pct);
          stop = stepped && s == 1 && pass == stop_pass;
          stopped |= stop;
          if (poke && stepped && s == 2 && s < total) begin
            cfg_loop_iter_v = 1'b1;
            cfg_loop_iter_loop_id = 3'd0;
            cfg_loop_iter = 16'($urandom);
            start = 1'b1;
          end
          if (stepped && s == total) begin
            if (rep && !stopped) begin
              want_init = 1;
              pass++;
            end else want_done = 1;
          end
          stl = stall;
          @(negedge clk);
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    stall = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    cfg_loop_iter_v = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("por");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("idle");
    wr(0, 2);
    wr(1, 1);
    do_run(2, 0, 0, 0, 0, 0);
    do_run(2, 0, 0, 40, 0, 0);
    wr(0, 3);
    do_run(1, 1, 1, 0, 0, 0);
    do_run(1, 1, 0, 30, 0, 0);
    wr(0, 0);
    do_run(1, 0, 0, 0, 0, 0);
    do_run(0, 0, 0, 0, 0, 0);
    do_run(12, 0, 0, 0, 0, 0);
    wr(0, 2);
    wr(1, 1);
    do_run(2, 0, 0, 20, 1, 0);
    do_run(2, 0, 0, 0, 0, 0);
    do_run(2, 0, 0, 0, 0, 3);
    do_run(2, 0, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) wr(i, i < 2 ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 1)));
      do_run(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 25, r % 3 == 0, 0);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/nested_loop_ctrl.md
Name: nested_loop_ctrl

Overview:
Parametrised nested-loop sequencer, successor to controller_fsm. Walks up to MAX_LOOPS nested loops, each with a programmable trip count, and emits one iteration step per un-stalled cycle. Adds a run-time loop count, a per-loop counter vector, a repeat mode and busy/done status. Sits between the instruction decoder, which supplies configuration, and the address generators and compute array, which consume the steps.

Parameters:
MAX_LOOPS, 8, number of loop levels supported; loop 0 is innermost.
LOOP_ID_W, 3, width of a loop id; must equal clog2(MAX_LOOPS).
LOOP_ITER_W, 16, trip-count and counter width per loop.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_loop_iter_v  in  1  write strobe for a trip count
cfg_loop_iter  in  LOOP_ITER_W  trip count minus 1 (value N gives N+1 iterations)
cfg_loop_iter_loop_id  in  LOOP_ID_W  loop being written
cfg_num_loops  in  LOOP_ID_W+1  active loop levels, 1..MAX_LOOPS; sampled on start
cfg_repeat  in  1  1 = restart automatically after completion; sampled on start
start  in  1  begin a run (accepted only in IDLE)
stop  in  1  in repeat mode, finish the current pass and then go IDLE
stall  in  1  freeze stepping
busy  out  1  high from the accepted start until the cycle done is asserted
done  out  1  1-cycle pulse after the final pass
loop_index  out  LOOP_ID_W  highest loop id that increments this step
loop_index_valid  out  1  a step occurred this cycle
loop_last_iter  out  1  final step of a pass (all counters at max)
loop_init  out  1  1-cycle pulse before the first step of each pass
loop_enter  out  1  first step of a pass
loop_exit  out  1  same cycle as loop_last_iter
loop_counters  out  MAX_LOOPS*LOOP_ITER_W  packed counters; loop i occupies bits [i*W +: W]

Behaviour:
- Reset: all outputs 0; counters 0; trip-count registers 0; state IDLE. Reset mid-run aborts immediately. No done pulse is produced.
- Config: trip-count writes are accepted only in IDLE and ignored otherwise. cfg_num_loops=0 is treated as 1; values above MAX_LOOPS saturate to MAX_LOOPS.
- States and transitions:
  - IDLE -> INIT when start=1. This latches the loop count and repeat flag and sets busy.
  - INIT (1 cycle): loop_init=1 and counters cleared. Next state is RUN.
  - RUN: each cycle with stall=0 is one step; stall=1 holds counters and drives all step outputs to 0.
    - Step rule: k is the lowest active loop i whose counter is below its max while all loops below i are at max. Loops below k clear to 0 and loop k increments. loop_index=k and loop_index_valid=1.
    - Final step: no such k exists. loop_last_iter=loop_exit=1, loop_index=num_loops-1, counters are held, and the state advances.
    - First step of a pass additionally asserts loop_enter=1.
  - After the final step:
    - If repeat=1 and stop has not been seen, go to INIT (back-to-back passes with 1 idle-step gap).
    - Otherwise go to DONE.
  - DONE (1 cycle): done=1 and busy=0. Next state is IDLE.
- stop is sticky once seen in INIT or RUN and clears on IDLE. It is ignored when repeat=0.
- start in any state other than IDLE is ignored.
- Inactive loops (id >= num_loops) hold their counters at 0 and never appear on loop_index.
- All-zero trip counts with num_loops=1: INIT, then a single step that is both enter and final (loop_enter, loop_last_iter and loop_exit all 1).
- A pass contains exactly the product of (trip+1) over active loops steps. Latency: start to first step = 2 cycles; final step to done = 1 cycle.
- All outputs are registered.

Decomposition:
- Shared package: state encoding (IDLE, INIT, RUN, DONE), and the LOOP_ITER_W/LOOP_ID_W defaults.
- Sub-module loop_counter_stage (one per loop):
  - Holds the trip register and counter.
  - Inputs: clear, inc, wrap, active.
  - Outputs: at_max and count.
- The top level holds the FSM and the priority-carry logic that selects k.

Test Plan:
1. Reset, then num_loops=2, trips {loop0=2, loop1=1}, start.
   - loop_init at cycle 1.
   - 6 steps with loop_index sequence 0,0,1,0,0,1(last).
   - loop_enter on step 1 and loop_exit on step 6; done 1 cycle later; busy 0 afterwards.
2. Same config with stall high on steps 2 and 4.
   - Counters are held and valid=0 during stalls.
   - Total 6 valid steps; done delayed by exactly 2 cycles.
3. repeat=1, num_loops=1, trip=3.
   - Two passes of 4 steps each, with loop_init between them.
   - Assert stop during the second pass: it completes, then done, then IDLE.
4. num_loops=1, trip=0: a single step with enter, last and exit together. Also num_loops=0 behaves identically.
5. Config writes to loop 0 and a start pulse issued mid-run are both ignored. Trips are unchanged at the next run and the step count is unchanged.
6. Assert reset at step 3 of a 2x3 run.
   - Next cycle: all outputs 0, state IDLE, no done pulse.
   - A fresh start after reset reruns cleanly with trips reset to 0.
